// File: rtl/bridge_rx_param_if.sv
// rtl/bridge_rx_param_if.sv - byte input and register bus signals of the parametrised hex bridge receiver
interface bridge_rx_param_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            data_i;
    logic                  valid_i;
    logic                  ready_i;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  rw_o;
    logic                  valid_o;
    logic                  err_o;

    // The bridge side: consumes UART bytes, drives the register bus.
    modport master (
        input  data_i,
        input  valid_i,
        input  ready_i,
        output addr_o,
        output data_o,
        output rw_o,
        output valid_o,
        output err_o
    );

    // The environment side: supplies bytes and accepts transactions.
    modport slave (
        output data_i,
        output valid_i,
        output ready_i,
        input  addr_o,
        input  data_o,
        input  rw_o,
        input  valid_o,
        input  err_o
    );
endinterface

// File: rtl/bridge_rx_param.sv
// rtl/bridge_rx_param.sv - ASCII-hex R/W/B command parser issuing register bus transactions
module bridge_rx_param #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int BURST_DIGITS   = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    bridge_rx_param_if.master bus
);
    localparam int AD  = ADDR_WIDTH / 4;
    localparam int DD  = DATA_WIDTH / 4;
    localparam int CW  = 4 * BURST_DIGITS;
    localparam int DCW = 6;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COUNT,
        ST_EOL,
        ST_ISSUE
    } state_e;

    typedef enum logic [1:0] {
        CMD_R,
        CMD_W,
        CMD_B
    } cmd_e;

    state_e                state, state_d;
    cmd_e                  cmd, cmd_d;
    logic [DCW-1:0]        digit_cnt, digit_d;
    logic [ADDR_WIDTH-1:0] addr_r, addr_d;
    logic [DATA_WIDTH-1:0] data_r, data_d;
    logic [CW-1:0]         cnt_r, cnt_d;
    logic [TW-1:0]         tmo_cnt, tmo_d;
    logic                  err_r, err_d;

    logic [4:0]            hex;
    logic                  is_eol;
    logic                  in_cmd;

    // Returns {is_hex, nibble}; accepts both upper and lower case letters.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, 4'(b[3:0] + 4'd9)};
        else
            return 5'b0;
    endfunction

    assign hex    = hex_decode(bus.data_i);
    assign is_eol = (bus.data_i == 8'h0D) || (bus.data_i == 8'h0A);
    assign in_cmd = (state != ST_IDLE) && (state != ST_ISSUE);

    // Bus outputs are forced to zero outside a pending transaction so that
    // an asynchronous reset clears them immediately through the state register.
    assign bus.valid_o = (state == ST_ISSUE);
    assign bus.addr_o  = bus.valid_o ? addr_r : '0;
    assign bus.rw_o    = bus.valid_o && (cmd == CMD_W);
    assign bus.data_o  = (bus.valid_o && cmd == CMD_W) ? data_r : '0;
    assign bus.err_o   = err_r;

    // State, field and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd       <= CMD_R;
            digit_cnt <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            cnt_r     <= '0;
            tmo_cnt   <= '0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_d;
            cmd       <= cmd_d;
            digit_cnt <= digit_d;
            addr_r    <= addr_d;
            data_r    <= data_d;
            cnt_r     <= cnt_d;
            tmo_cnt   <= tmo_d;
            err_r     <= err_d;
        end
    end

    // Next-state, field accumulation, burst stepping, error and timeout logic.
    always_comb begin
        state_d = state;
        cmd_d   = cmd;
        digit_d = digit_cnt;
        addr_d  = addr_r;
        data_d  = data_r;
        cnt_d   = cnt_r;
        err_d   = 1'b0;
        tmo_d   = '0;

        if (in_cmd && !bus.valid_i)
            tmo_d = tmo_cnt + TW'(1);

        case (state)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    if (bus.data_i == 8'h52 || bus.data_i == 8'h57 || bus.data_i == 8'h42) begin
                        cmd_d   = (bus.data_i == 8'h52) ? CMD_R :
                                  (bus.data_i == 8'h57) ? CMD_W : CMD_B;
                        digit_d = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.valid_i) begin
                    if (hex[4]) begin
                        addr_d = (addr_r << 4) | ADDR_WIDTH'(hex[3:0]);
                        if (digit_cnt == DCW'(AD - 1)) begin
                            digit_d = '0;
                            state_d = (cmd == CMD_W) ? ST_DATA :
                                      (cmd == CMD_B) ? ST_COUNT : ST_EOL;
                        end else begin
                            digit_d = digit_cnt + DCW'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bus.valid_i) begin
                    if (hex[4]) begin
                        data_d = (data_r << 4) | DATA_WIDTH'(hex[3:0]);
                        if (digit_cnt == DCW'(DD - 1)) begin
                            digit_d = '0;
                            state_d = ST_EOL;
                        end else begin
                            digit_d = digit_cnt + DCW'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COUNT: begin
                if (bus.valid_i) begin
                    if (hex[4]) begin
                        cnt_d = (cnt_r << 4) | CW'(hex[3:0]);
                        if (digit_cnt == DCW'(BURST_DIGITS - 1)) begin
                            digit_d = '0;
                            state_d = ST_EOL;
                        end else begin
                            digit_d = digit_cnt + DCW'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EOL: begin
                if (bus.valid_i) begin
                    if (!is_eol) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cmd == CMD_B && cnt_r == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A byte arriving here is an overrun: flagged and dropped,
                // while any transfer on the same edge still completes.
                if (bus.valid_i)
                    err_d = 1'b1;
                if (bus.ready_i) begin
                    if (cmd == CMD_B && cnt_r > CW'(1)) begin
                        cnt_d  = cnt_r - CW'(1);
                        addr_d = addr_r + ADDR_WIDTH'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (TIMEOUT_CYCLES > 0 && in_cmd && !bus.valid_i && tmo_cnt == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
    end
endmodule
